obc_slice_accumulator: RTL and testbench

Bit-serial driver and shift-accumulator for the offset-binary-coding (OBC) 16-point DFT datapath. It captures 16 parallel two's-complement samples and drives one bit-slice per cycle, MSB first, onto the 16 select bits of a combinational per-bin partial-product ROM (real or imaginary). Each cycle it sums the ROM's 8 returned 32-bit partial products and shift-accumulates them into a full-precision DFT bin result. One instance sits beside each bin ROM and closes the loop between sample storage and ROM.

---
 rtl/obc_slice_accumulator.sv | 198 +++++++++++++++++++
 tb/tb_obc_slice_accumulator.sv | 269 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/obc_slice_accumulator.sv
// ---------------------------------------------------------------------------
// obc_slice_accumulator
//
// Purpose:
//   Bit-serial driver and shift-accumulator for one bin of the offset-binary-
//   coding 16-point DFT datapath. A transform starts by capturing 16 parallel
//   two's-complement samples. The block then presents one bit-slice per cycle,
//   MSB first, to a combinational partial-product ROM. It sums the ROM's 8
//   partial products and shift-accumulates them into a full-precision bin
//   value. Finally it adds the bin's OBC offset constant and presents the result.
//
// Ports:
//   i_clk         sole clock, rising edge
//   i_rst         asynchronous active-high reset
//   i_start       transform request, only looked at while idle
//   i_samples     16 samples, sample i at [i*DATA_W +: DATA_W]
//   i_offset_in   signed OBC offset for this bin, captured with i_start
//   o_x_bits      current bit-slice driving the ROM select inputs
//   i_rom_in0..7  signed partial products returned by the ROM for o_x_bits
//   o_busy        high while slices are being accumulated
//   o_done        one-cycle pulse, o_result is valid
//   o_result      signed bin value, held until the next o_done
// ---------------------------------------------------------------------------
module obc_slice_accumulator #(
    parameter  int DATA_W = 8,
    parameter  int ROM_W  = 32,
    localparam int RES_W  = ROM_W + 3 + DATA_W - 1
) (
    input  logic                      i_clk,
    input  logic                      i_rst,
    input  logic                      i_start,
    input  logic [16*DATA_W-1:0]      i_samples,
    input  logic signed [ROM_W-1:0]   i_offset_in,
    output logic [15:0]               o_x_bits,
    input  logic signed [ROM_W-1:0]   i_rom_in0,
    input  logic signed [ROM_W-1:0]   i_rom_in1,
    input  logic signed [ROM_W-1:0]   i_rom_in2,
    input  logic signed [ROM_W-1:0]   i_rom_in3,
    input  logic signed [ROM_W-1:0]   i_rom_in4,
    input  logic signed [ROM_W-1:0]   i_rom_in5,
    input  logic signed [ROM_W-1:0]   i_rom_in6,
    input  logic signed [ROM_W-1:0]   i_rom_in7,
    output logic                      o_busy,
    output logic                      o_done,
    output logic signed [RES_W-1:0]   o_result
);

    localparam int CNT_W = (DATA_W > 1) ? $clog2(DATA_W) : 1;
    localparam int SUM_W = ROM_W + 3;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_RUN,
        ST_DONE
    } state_t;

    state_t                    r_state;
    state_t                    w_nextState;

    logic [DATA_W-1:0]         r_shift [16];
    logic [15:0]               r_xBits;
    logic [CNT_W-1:0]          r_count;
    logic signed [RES_W-1:0]   r_acc;
    logic signed [RES_W-1:0]   r_result;
    logic signed [ROM_W-1:0]   r_offset;

    logic [DATA_W-1:0]         w_sample [16];
    logic signed [ROM_W-1:0]   w_rom [8];
    logic signed [SUM_W-1:0]   w_sliceSum;
    logic signed [RES_W-1:0]   w_sumExt;
    logic signed [RES_W-1:0]   w_offsetExt;
    logic signed [RES_W-1:0]   w_accNext;
    logic                      w_capture;
    logic                      w_firstSlice;
    logic                      w_lastSlice;

    // Split the flat sample bus into per-sample words so the capture loop
    // below can address them by index.
    always_comb begin
        for (int i = 0; i < 16; i++) begin
            w_sample[i] = i_samples[i*DATA_W +: DATA_W];
        end
    end

    // Gather the eight ROM outputs into an array and add them together. The
    // sum is three bits wider than one partial product, so it can never
    // overflow.
    always_comb begin
        w_rom[0] = i_rom_in0;
        w_rom[1] = i_rom_in1;
        w_rom[2] = i_rom_in2;
        w_rom[3] = i_rom_in3;
        w_rom[4] = i_rom_in4;
        w_rom[5] = i_rom_in5;
        w_rom[6] = i_rom_in6;
        w_rom[7] = i_rom_in7;
        w_sliceSum = '0;
        for (int k = 0; k < 8; k++) begin
            w_sliceSum = w_sliceSum + SUM_W'(w_rom[k]);
        end
    end

    // The MSB slice carries negative weight in two's complement, so the first
    // slice seeds the accumulator with -S. Every later slice doubles the
    // running value and adds S. RES_W leaves room for DATA_W-1 doublings, so
    // no wrap can occur.
    always_comb begin
        w_sumExt    = RES_W'(w_sliceSum);
        w_offsetExt = RES_W'(r_offset);
        if (w_firstSlice) begin
            w_accNext = -w_sumExt;
        end else begin
            w_accNext = (r_acc <<< 1) + w_sumExt;
        end
    end

    assign w_capture    = (r_state == ST_IDLE) && i_start;
    assign w_firstSlice = (r_count == CNT_W'(DATA_W - 1));
    assign w_lastSlice  = (r_state == ST_RUN) && (r_count == '0);

    // State register for the IDLE -> RUN -> DONE sequence.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_nextState;
        end
    end

    // Next-state and status decode. RUN lasts until the slice counter has
    // consumed the LSB slice. DONE is always exactly one cycle, which gives
    // the one-cycle o_done pulse.
    always_comb begin
        w_nextState = r_state;
        o_busy      = 1'b0;
        o_done      = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (i_start) begin
                    w_nextState = ST_RUN;
                end
            end
            ST_RUN: begin
                o_busy = 1'b1;
                if (r_count == '0) begin
                    w_nextState = ST_DONE;
                end
            end
            ST_DONE: begin
                o_done      = 1'b1;
                w_nextState = ST_IDLE;
            end
            default: begin
                w_nextState = ST_IDLE;
            end
        endcase
    end

    // Datapath registers. o_x_bits is a true register, so the slice for a RUN
    // cycle must already be loaded on the edge before that cycle. On capture,
    // the MSBs go straight into r_xBits and each shift register keeps the
    // remaining bits, left-aligned. Each RUN edge then pops the next bit.
    // After the last slice, r_xBits clears so the ROM sees zero in DONE.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_xBits  <= '0;
            r_count  <= '0;
            r_acc    <= '0;
            r_result <= '0;
            r_offset <= '0;
            for (int i = 0; i < 16; i++) begin
                r_shift[i] <= '0;
            end
        end else if (w_capture) begin
            r_offset <= i_offset_in;
            r_acc    <= '0;
            r_count  <= CNT_W'(DATA_W - 1);
            for (int i = 0; i < 16; i++) begin
                r_xBits[i] <= w_sample[i][DATA_W-1];
                r_shift[i] <= w_sample[i] << 1;
            end
        end else if (r_state == ST_RUN) begin
            r_acc   <= w_accNext;
            r_count <= r_count - CNT_W'(1);
            for (int i = 0; i < 16; i++) begin
                r_xBits[i] <= w_lastSlice ? 1'b0 : r_shift[i][DATA_W-1];
                r_shift[i] <= r_shift[i] << 1;
            end
            if (w_lastSlice) begin
                r_result <= w_accNext + w_offsetExt;
            end
        end
    end

    assign o_x_bits = r_xBits;
    assign o_result = r_result;

endmodule

// File: tb/tb_obc_slice_accumulator.sv
// ---------------------------------------------------------------------------
// tb_obc_slice_accumulator
//
// Purpose:
//   Directed bench for obc_slice_accumulator. A behavioural ROM sits on the
//   x_bits/rom_in loop and has three modes: all partial products = 1, only
//   rom_in0 = 1, or an OBC table for the imaginary part of bin 9. Expected
//   results are pushed to a queue when a start is driven. A monitor pops one
//   entry and compares it on every done pulse.
// ---------------------------------------------------------------------------
module tb_obc_slice_accumulator;

    localparam int DATA_W = 8;
    localparam int ROM_W  = 32;
    localparam int RES_W  = ROM_W + 3 + DATA_W - 1;

    logic                     clk = 1'b0;
    logic                     rst = 1'b1;
    logic                     start = 1'b0;
    logic [16*DATA_W-1:0]     samples = '0;
    logic signed [ROM_W-1:0]  offsetIn = '0;
    logic [15:0]              xBits;
    logic signed [ROM_W-1:0]  romIn [8];
    logic                     busy;
    logic                     done;
    logic signed [RES_W-1:0]  result;

    int checks = 0;
    int errors = 0;
    int cycle = 0;
    int doneCount = 0;
    int pushCount = 0;
    int romMode = 0;
    int lastDoneCycle = -1;
    bit spacingOn = 1'b0;
    logic signed [63:0] expQ [$];
    logic signed [ROM_W-1:0] offTab;

    // Bin-9 imaginary coefficients -sin(2*pi*9*i/16), scaled by 2^20.
    int coef [16] = '{0, 401273, -741455, 968758, -1048576, 968758, -741455, 401273,
                      0, -401273, 741455, -968758, 1048576, -968758, 741455, -401273};

    obc_slice_accumulator #(.DATA_W(DATA_W), .ROM_W(ROM_W)) dut (
        .i_clk       (clk),
        .i_rst       (rst),
        .i_start     (start),
        .i_samples   (samples),
        .i_offset_in (offsetIn),
        .o_x_bits    (xBits),
        .i_rom_in0   (romIn[0]),
        .i_rom_in1   (romIn[1]),
        .i_rom_in2   (romIn[2]),
        .i_rom_in3   (romIn[3]),
        .i_rom_in4   (romIn[4]),
        .i_rom_in5   (romIn[5]),
        .i_rom_in6   (romIn[6]),
        .i_rom_in7   (romIn[7]),
        .o_busy      (busy),
        .o_done      (done),
        .o_result    (result)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cycle++;

    // Behavioural ROM. In table mode, output k covers inputs 2k and 2k+1 with
    // OBC weights: +c when the bit is 1, -c when it is 0.
    always_comb begin
        for (int k = 0; k < 8; k++) begin
            romIn[k] = '0;
            case (romMode)
                0: romIn[k] = 32'sd1;
                1: romIn[k] = (k == 0) ? 32'sd1 : 32'sd0;
                default: romIn[k] = ROM_W'((xBits[2*k] ? coef[2*k] : -coef[2*k]) +
                                           (xBits[2*k+1] ? coef[2*k+1] : -coef[2*k+1]));
            endcase
        end
    end

    // With the OBC table and offset -sum(c), the bin value is sum(2*c_i*x_i).
    function automatic logic signed [63:0] refResult(input logic [16*DATA_W-1:0] s);
        longint acc = 0;
        for (int i = 0; i < 16; i++) begin
            acc += longint'($signed(s[i*DATA_W +: DATA_W])) * 2 * longint'(coef[i]);
        end
        return acc;
    endfunction

    function automatic logic [16*DATA_W-1:0] randSamples();
        logic [16*DATA_W-1:0] r;
        for (int i = 0; i < 16; i++) begin
            r[i*DATA_W +: DATA_W] = DATA_W'($urandom);
        end
        return r;
    endfunction

    task automatic checkOutput(input string tag, input logic signed [63:0] observed,
                               input logic signed [63:0] expected);
        checks++;
        assert (observed === expected) else begin
            errors++;
            $error("[TB] FAIL %s observed=%0d expected=%0d", tag, observed, expected);
        end
    endtask

    // Drive one start pulse, queueing the expected result when the transform
    // is meant to complete. Return at the falling edge after the capture edge
    // with start low, and scramble the inputs, which the DUT must ignore now.
    task automatic applyStimulus(input logic [16*DATA_W-1:0] s, input logic signed [ROM_W-1:0] off,
                                 input logic signed [63:0] expected, input bit expectDone);
        samples  = s;
        offsetIn = off;
        start    = 1'b1;
        if (expectDone) begin
            expQ.push_back(expected);
            pushCount++;
        end
        @(posedge clk);
        @(negedge clk);
        start    = 1'b0;
        samples  = randSamples();
        offsetIn = ROM_W'($urandom);
    endtask

    task automatic waitDone(input string tag);
        int n = 0;
        while (done !== 1'b1 && n < 20) begin
            @(negedge clk);
            n++;
        end
        checks++;
        assert (done === 1'b1) else begin
            errors++;
            $error("[TB] FAIL %s timeout observed=no done expected=done", tag);
        end
        @(negedge clk);
    endtask

    // Scoreboard monitor: every done must match the oldest queued result.
    always @(negedge clk) begin
        logic signed [63:0] expected;
        if (rst === 1'b0 && done === 1'b1) begin
            doneCount++;
            if (spacingOn && lastDoneCycle >= 0) begin
                checkOutput("doneSpacing", 64'(cycle - lastDoneCycle), 64'sd10);
            end
            lastDoneCycle = cycle;
            checks++;
            assert (expQ.size() > 0) else begin
                errors++;
                $error("[TB] FAIL unexpectedDone observed=done expected=no done");
            end
            if (expQ.size() > 0) begin
                expected = expQ.pop_front();
                checkOutput("result", 64'(result), expected);
            end
        end
    end

    initial begin
        #1000000;
        $display("[TB] FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        logic [16*DATA_W-1:0] s;
        logic [15:0] xExp [9];
        int sumC = 0;
        for (int i = 0; i < 16; i++) sumC += coef[i];
        offTab = ROM_W'(-sumC);
        xExp = '{16'h0000, 16'h0000, 16'h0000, 16'h0000, 16'hFF00,
                 16'hF0F0, 16'hCCCC, 16'hAAAA, 16'h0000};

        // Reset state
        rst = 1'b1;
        repeat (3) @(negedge clk);
        checkOutput("resetBusy", 64'(busy), 64'sd0);
        checkOutput("resetDone", 64'(done), 64'sd0);
        checkOutput("resetXBits", 64'(xBits), 64'sd0);
        checkOutput("resetResult", 64'(result), 64'sd0);
        rst = 1'b0;
        @(negedge clk);

        // Constant ROM: S = 8 every slice gives -8, with done 9 edges after start
        romMode = 0;
        applyStimulus(randSamples(), '0, -64'sd8, 1'b1);
        for (int k = 0; k <= 9; k++) begin
            if (k > 0) @(negedge clk);
            checkOutput($sformatf("constBusy_k%0d", k), 64'(busy), 64'(k <= 7));
            checkOutput($sformatf("constDone_k%0d", k), 64'(done), 64'(k == 8));
        end

        // Offset path: S = 1 gives -1, plus an offset of 5
        romMode = 1;
        applyStimulus(randSamples(), 32'sd5, 64'sd4, 1'b1);
        waitDone("offset");

        // Slice ordering with sample i = i
        romMode = 2;
        for (int i = 0; i < 16; i++) s[i*DATA_W +: DATA_W] = DATA_W'(i);
        applyStimulus(s, offTab, refResult(s), 1'b1);
        for (int k = 0; k <= 8; k++) begin
            if (k > 0) @(negedge clk);
            checkOutput($sformatf("xBits_k%0d", k), 64'(xBits), 64'(xExp[k]));
        end
        @(negedge clk);

        // start pulsed during RUN and during DONE must be ignored
        s = randSamples();
        applyStimulus(s, offTab, refResult(s), 1'b1);
        repeat (2) @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (5) @(negedge clk);
        checkOutput("ignoreDonePhase", 64'(done), 64'sd1);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (12) @(negedge clk);
        checkOutput("ignoreBusyIdle", 64'(busy), 64'sd0);
        checkOutput("ignoreDoneCount", 64'(doneCount), 64'(pushCount));

        // Reset at RUN cycle 4 aborts without a done
        s = randSamples();
        applyStimulus(s, offTab, 64'sd0, 1'b0);
        repeat (3) @(negedge clk);
        rst = 1'b1;
        #1;
        checkOutput("abortBusy", 64'(busy), 64'sd0);
        checkOutput("abortXBits", 64'(xBits), 64'sd0);
        checkOutput("abortResult", 64'(result), 64'sd0);
        checkOutput("abortDone", 64'(done), 64'sd0);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        repeat (12) @(negedge clk);
        checkOutput("abortDoneCount", 64'(doneCount), 64'(pushCount));
        s = randSamples();
        applyStimulus(s, offTab, refResult(s), 1'b1);
        waitDone("afterAbort");

        // Golden: 200 back-to-back transforms with start held high
        lastDoneCycle = -1;
        spacingOn = 1'b1;
        for (int t = 0; t < 200; t++) begin
            if (t == 0) s = {16{8'h80}};
            else if (t == 1) s = {16{8'h7F}};
            else s = randSamples();
            samples  = s;
            offsetIn = offTab;
            start    = 1'b1;
            expQ.push_back(refResult(s));
            pushCount++;
            repeat (10) @(posedge clk);
            @(negedge clk);
        end
        start = 1'b0;
        repeat (3) @(negedge clk);
        spacingOn = 1'b0;
        checkOutput("goldenQueueEmpty", 64'(expQ.size()), 64'sd0);
        checkOutput("goldenDoneCount", 64'(doneCount), 64'(pushCount));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
